// File: rtl/data_memory_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// The access-size and FSM-state encodings live here.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

    // True for an illegal size or an address not aligned to the access size.
    function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic bad;
        case (size)
            MEM_BYTE: bad = 1'b0;
            MEM_HALF: bad = lsb[0];
            MEM_WORD: bad = |lsb;
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Load/store request/response bus between the core (master) and the responder (slave).
interface data_memory_responder_if #(
    parameter int unsigned RegBits = 32
) ();

    logic               req_valid_i;
    logic               req_ready_o;
    logic [RegBits-1:0] req_addr_i;
    logic               req_we_i;
    logic [1:0]         req_size_i;
    logic               req_unsigned_i;
    logic [RegBits-1:0] req_wdata_i;
    logic               rsp_valid_o;
    logic               rsp_ready_i;
    logic [RegBits-1:0] rsp_rdata_o;
    logic               rsp_err_o;

    modport master (
        output req_valid_i, req_addr_i, req_we_i, req_size_i, req_unsigned_i, req_wdata_i,
        output rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_we_i, req_size_i, req_unsigned_i, req_wdata_i,
        input  rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

endinterface

// File: rtl/data_memory_responder_mem_lane_align.sv
// Byte-lane steering: store byte enables / shifted data, and load extraction with extension.
module mem_lane_align
    import riscv_mem_pkg::*;
#(
    parameter int unsigned RegBits = 32
) (
    input  logic [1:0]         size,
    input  logic [1:0]         addr_lsb,
    input  logic               is_unsigned,
    input  logic [RegBits-1:0] wdata,
    input  logic [RegBits-1:0] rword,
    output logic [3:0]         be,
    output logic [RegBits-1:0] wdata_lane,
    output logic [RegBits-1:0] rdata
);

    logic [RegBits-1:0] shifted;

    always_comb begin
        be         = 4'b0000;
        wdata_lane = '0;
        case (size)
            MEM_BYTE: begin
                be         = 4'b0001 << addr_lsb;
                wdata_lane = wdata << {addr_lsb, 3'b000};
            end
            MEM_HALF: begin
                be         = 4'b0011 << {addr_lsb[1], 1'b0};
                wdata_lane = wdata << {addr_lsb[1], 4'b0000};
            end
            MEM_WORD: begin
                be         = 4'b1111;
                wdata_lane = wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = rword >> {addr_lsb, 3'b000};
        case (size)
            MEM_BYTE: rdata = {{(RegBits-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
            MEM_HALF: rdata = {{(RegBits-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
            MEM_WORD: rdata = rword;
            default:  rdata = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_responder.sv
// Load/store responder: one request at a time, WaitStates cycles of delay, word-organised RAM.
module data_memory_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned RegBits    = 32,
    parameter int unsigned DepthWords = 256,
    parameter int unsigned WaitStates = 1
) (
    input logic                     clk_i,
    input logic                     rst_i,
    data_memory_responder_if.slave  bus
);

    localparam int unsigned IdxW = $clog2(DepthWords);
    localparam int unsigned CntW = (WaitStates > 1) ? $clog2(WaitStates) : 1;

    resp_state_t        state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               ready_en_q;
    logic [RegBits-1:0] addr_q, wdata_q;
    logic               we_q, uns_q;
    logic [1:0]         size_q;
    logic [RegBits-1:0] rdata_q;
    logic               err_q;

    logic [RegBits-1:0] mem [DepthWords];

    logic               hs;
    logic               acc_fire, acc_err, acc_we, acc_uns;
    logic [RegBits-1:0] acc_addr, acc_wdata;
    logic [1:0]         acc_size;
    logic [IdxW-1:0]    acc_idx;
    logic [3:0]         be;
    logic [RegBits-1:0] wdata_lane, load_data;

    assign hs = bus.req_valid_i & bus.req_ready_o;

    // With no wait states the access uses the live request in its handshake cycle.
    always_comb begin
        if (WaitStates == 0) begin
            acc_fire  = hs;
            acc_addr  = bus.req_addr_i;
            acc_we    = bus.req_we_i;
            acc_size  = bus.req_size_i;
            acc_uns   = bus.req_unsigned_i;
            acc_wdata = bus.req_wdata_i;
        end else begin
            acc_fire  = (state_q == WAIT) && (cnt_q == '0);
            acc_addr  = addr_q;
            acc_we    = we_q;
            acc_size  = size_q;
            acc_uns   = uns_q;
            acc_wdata = wdata_q;
        end
    end

    assign acc_err = mem_misaligned(acc_size, acc_addr[1:0]) | ((acc_addr >> (IdxW + 2)) != '0);
    assign acc_idx = acc_addr[IdxW+1:2];

    mem_lane_align #(
        .RegBits (RegBits)
    ) u_lane_align (
        .size        (acc_size),
        .addr_lsb    (acc_addr[1:0]),
        .is_unsigned (acc_uns),
        .wdata       (acc_wdata),
        .rword       (mem[acc_idx]),
        .be          (be),
        .wdata_lane  (wdata_lane),
        .rdata       (load_data)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    if (WaitStates == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CntW'(WaitStates - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            RESP: begin
                if (bus.rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ready_en_q keeps req_ready_o low until the first edge after reset releases.
    always_comb begin
        bus.req_ready_o = (state_q == IDLE) & ready_en_q;
        bus.rsp_valid_o = (state_q == RESP);
        bus.rsp_rdata_o = rdata_q;
        bus.rsp_err_o   = err_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ready_en_q <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (hs) begin
                addr_q  <= bus.req_addr_i;
                we_q    <= bus.req_we_i;
                size_q  <= bus.req_size_i;
                uns_q   <= bus.req_unsigned_i;
                wdata_q <= bus.req_wdata_i;
            end
            if (acc_fire) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || acc_we) ? '0 : load_data;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc_fire && acc_we && !acc_err) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[acc_idx][8*k +: 8] <= wdata_lane[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomised bench for data_memory_responder against a byte-array reference model.
module tb_data_memory_responder;

    localparam int unsigned WS    = 1;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned BYTES = DEPTH * 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;

    logic [7:0] ref_mem [BYTES];

    data_memory_responder_if #(.RegBits(32)) bus ();

    data_memory_responder #(
        .RegBits    (32),
        .DepthWords (DEPTH),
        .WaitStates (WS)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
               (a >= BYTES);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input logic uns);
        logic [31:0] v;
        int nb;
        nb = 1 << sz;
        v  = 0;
        for (int i = 0; i < nb; i++) v = v | ({24'd0, ref_mem[int'(a) + i]} << (8 * i));
        if (!uns && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!uns && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    endtask

    // Entered at a negedge; returns just after the handshake edge.
    task automatic req_issue(input logic [31:0] a, input logic we, input logic [1:0] sz,
                             input logic uns, input logic [31:0] wd);
        int waited;
        bus.req_valid_i    = 1'b1;
        bus.req_addr_i     = a;
        bus.req_we_i       = we;
        bus.req_size_i     = sz;
        bus.req_unsigned_i = uns;
        bus.req_wdata_i    = wd;
        waited = 0;
        while (!bus.req_ready_o && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check_val("req_ready", {31'd0, bus.req_ready_o}, 32'd1);
        @(posedge clk);
    endtask

    // Entered just after the handshake edge; returns at a negedge after taking the response.
    task automatic rsp_collect(output logic [31:0] rd, output logic er);
        int lat;
        lat = 1;
        @(negedge clk);
        bus.req_valid_i    = 1'b0;
        bus.req_addr_i     = $urandom;
        bus.req_we_i       = 1'($urandom);
        bus.req_size_i     = 2'($urandom);
        bus.req_unsigned_i = 1'($urandom);
        bus.req_wdata_i    = $urandom;
        while (!bus.rsp_valid_o && lat < 40) begin
            bus.rsp_ready_i = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        check_val("latency", 32'(lat), 32'(WS + 1));
        rd = bus.rsp_rdata_o;
        er = bus.rsp_err_o;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic txn(input string tag, input logic [31:0] a, input logic we,
                       input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
        logic        e_err;
        logic [31:0] e_rd;
        e_err = model_err(a, sz);
        e_rd  = (e_err || we) ? 32'd0 : model_load(a, sz, uns);
        req_issue(a, we, sz, uns, wd);
        rsp_collect(rd, er);
        check_val({tag, "_err"}, {31'd0, er}, {31'd0, e_err});
        check_val({tag, "_rdata"}, rd, e_rd);
        if (we && !e_err) model_store(a, sz, wd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, rd0, a;
        logic        er, er0;
        logic [1:0]  sz;

        bus.req_valid_i    = 1'b0;
        bus.req_addr_i     = '0;
        bus.req_we_i       = 1'b0;
        bus.req_size_i     = 2'd0;
        bus.req_unsigned_i = 1'b0;
        bus.req_wdata_i    = '0;
        bus.rsp_ready_i    = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check_val("rst_ready_low", {31'd0, bus.req_ready_o}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("idle_ready", {31'd0, bus.req_ready_o}, 32'd1);
        check_val("idle_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        check_val("idle_rdata", bus.rsp_rdata_o, 32'd0);
        check_val("idle_err", {31'd0, bus.rsp_err_o}, 32'd0);

        for (int w = 0; w < 20; w++) txn("fill", 32'(w * 4), 1'b1, 2'd2, 1'b0, $urandom, rd, er);

        txn("st_word", 32'h10, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, rd, er);
        txn("ld_word", 32'h10, 1'b0, 2'd2, 1'b0, 32'h0, rd, er);
        check_val("ld_deadbeef", rd, 32'hDEAD_BEEF);
        txn("st_byte", 32'h11, 1'b1, 2'd0, 1'b0, 32'h0000_0080, rd, er);
        txn("ld_sbyte", 32'h11, 1'b0, 2'd0, 1'b0, 32'h0, rd, er);
        check_val("sbyte_val", rd, 32'hFFFF_FF80);
        txn("ld_ubyte", 32'h11, 1'b0, 2'd0, 1'b1, 32'h0, rd, er);
        check_val("ubyte_val", rd, 32'h0000_0080);
        txn("ld_merge", 32'h10, 1'b0, 2'd2, 1'b0, 32'h0, rd, er);
        check_val("merge_val", rd, 32'hDEAD_80EF);
        txn("ld_mis_half", 32'h13, 1'b0, 2'd1, 1'b0, 32'h0, rd, er);
        check_val("mis_half_err", {31'd0, er}, 32'd1);
        txn("st_oob", 32'h400, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, rd, er);
        check_val("oob_err", {31'd0, er}, 32'd1);
        txn("ld_after_err", 32'h10, 1'b0, 2'd2, 1'b0, 32'h0, rd, er);
        check_val("after_err_val", rd, 32'hDEAD_80EF);

        // Response stalled with a new request waiting on the inputs.
        req_issue(32'h10, 1'b0, 2'd2, 1'b0, 32'h0);
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'h30;
        bus.req_we_i    = 1'b1;
        bus.req_size_i  = 2'd2;
        bus.req_wdata_i = 32'hA5A5_5A5A;
        for (int i = 0; i < 40 && !bus.rsp_valid_o; i++) @(negedge clk);
        rd0 = bus.rsp_rdata_o;
        er0 = bus.rsp_err_o;
        check_val("stall_rdata", rd0, model_load(32'h10, 2'd2, 1'b0));
        check_val("stall_err", {31'd0, er0}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("stall_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
            check_val("stall_hold", bus.rsp_rdata_o, model_load(32'h10, 2'd2, 1'b0));
            check_val("stall_err_hold", {31'd0, bus.rsp_err_o}, 32'd0);
            check_val("stall_req_ready", {31'd0, bus.req_ready_o}, 32'd0);
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        check_val("post_rsp_ready", {31'd0, bus.req_ready_o}, 32'd1);
        check_val("post_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        @(posedge clk);
        rsp_collect(rd, er);
        check_val("held_st_err", {31'd0, er}, 32'd0);
        check_val("held_st_rdata", rd, 32'd0);
        model_store(32'h30, 2'd2, 32'hA5A5_5A5A);

        for (int n = 0; n < 80; n++) begin
            a  = ($urandom_range(0, 7) == 0) ? 32'h400 + $urandom_range(0, 255)
                                             : 32'($urandom_range(0, 'h4F));
            sz = 2'($urandom);
            txn("rnd", a, 1'($urandom), sz, 1'($urandom), $urandom, rd, er);
        end

        // Reset pulsed while a store is still waiting for its access edge.
        txn("pre_rst_ld", 32'h10, 1'b0, 2'd2, 1'b0, 32'h0, rd, er);
        req_issue(32'h20, 1'b1, 2'd2, 1'b0, 32'h1234_5678);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("arst_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        check_val("arst_ready", {31'd0, bus.req_ready_o}, 32'd0);
        check_val("arst_rdata", bus.rsp_rdata_o, 32'd0);
        check_val("arst_err", {31'd0, bus.rsp_err_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("rerst_ready", {31'd0, bus.req_ready_o}, 32'd1);
        txn("post_rst_ld", 32'h20, 1'b0, 2'd2, 1'b0, 32'h0, rd, er);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the core's load/store port; the core side issues requests and this block services them.
- Accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- Performs byte/half/word stores with lane masking, and returns sign- or zero-extended load data with an error flag.
- Sits between the core's load/store path and a word-organised RAM array held inside this block.

Parameters:
- RegBits, 32, data and address width.
- DepthWords, 256, number of RegBits-wide words; must be a power of two.
- WaitStates, 1, cycles between request acceptance and memory access; 0 is legal.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- req_addr_i  in  RegBits  byte address.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  1 = zero-extend load data, 0 = sign-extend.
- req_wdata_i  in  RegBits  store data, right-aligned.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  requester takes the response.
- rsp_rdata_o  out  RegBits  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  misaligned, out-of-range or illegal-size access.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - FSM goes to IDLE, wait counter clears.
  - req_ready_o=0 while reset is asserted; it becomes 1 in the first cycle after rst_i rises.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - RAM contents are not reset.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready_o=1.
  - A handshake (req_valid_i & req_ready_o) registers addr, we, size, unsigned and wdata.
  - If WaitStates>0: go to WAIT with counter=WaitStates-1.
  - If WaitStates=0: perform the access in the handshake cycle and go to RESP.
- WAIT:
  - req_ready_o=0.
  - The counter decrements each cycle.
  - When counter=0, perform the access at that clock edge and go to RESP.
- RESP:
  - rsp_valid_o=1; rdata and err are stable until the response is taken.
  - When rsp_ready_i=1, go to IDLE; the next request can be accepted one cycle later.
  - There is no same-cycle response-to-request bypass, so at most one request is outstanding.
- Latency: handshake edge to rsp_valid_o is WaitStates+1 cycles.
- Error conditions (set rsp_err_o):
  - size=11.
  - half access with addr[0]=1.
  - word access with addr[1:0]!=0.
  - addr >= DepthWords*4.
- On error: no RAM write, rsp_rdata_o=0, the FSM still passes through WAIT/RESP with normal latency.
- Word index is addr[log2(DepthWords)+1:2].
- Store lane rules:
  - byte: byte lane addr[1:0] gets wdata[7:0].
  - half: lanes addr[1]*2 and addr[1]*2+1 get wdata[15:0].
  - word: all lanes written.
  - Untouched lanes keep their old value.
  - rsp_rdata_o=0 for stores.
- Load: extract the addressed byte/half/word, then extend to RegBits by req_unsigned_i.
- Reset mid-operation: a pending access that has not reached its access edge is dropped, with no write. A response in RESP is discarded.
- rsp_ready_i held high in IDLE/WAIT has no effect.
- req_* inputs outside the IDLE handshake are ignored; the registered copy is used.

Decomposition:
- Package riscv_mem_pkg:
  - enum mem_size_t (MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10).
  - enum resp_state_t (IDLE, WAIT, RESP).
  - function for the alignment check.
- Sub-module mem_lane_align, purely combinational:
  - Store path: from size, addr[1:0] and wdata, produce a 4-bit byte enable and lane-shifted write data.
  - Load path: from size, unsigned, addr[1:0] and the RAM word, produce extended read data.
- Top level holds the FSM, wait counter, request registers and RAM array.

Test Plan:
- Reset then idle, WaitStates=1 -> req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
- Word store 0xDEADBEEF at 0x10, then word load 0x10 -> rsp_rdata_o=0xDEADBEEF, err=0, rsp_valid_o rises 2 cycles after each handshake.
- Byte store 0x80 at 0x11, then signed byte load 0x11 -> 0xFFFFFF80; unsigned byte load -> 0x00000080; word load 0x10 -> 0xDEAD80EF.
- Half load at 0x13, and word store at DepthWords*4 (0x400) -> err=1, rdata=0, following word load 0x10 still returns 0xDEAD80EF.
- rsp_ready_i held 0 for 5 cycles in RESP -> rsp_valid_o, rdata and err stable; req_ready_o=0 with a new request held on the inputs; that request is accepted 1 cycle after the response handshake.
- rst_i pulsed low during WAIT of a store of 0x12345678 to 0x20 -> outputs clear asynchronously; after reset, word load 0x20 returns its previously written value, not 0x12345678.
